cfo_sample_capture: RTL

CFO_SAMPLE_CAPTURE -- requirements
Module: cfo_sample_capture

---
 rtl/cfo_sample_capture.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cfo_sample_capture.sv
// Frame capture buffer for CFO estimation. It fills DEPTH complex samples, then
// serves single or dual (lagged) reads with one cycle of latency.
module cfo_sample_capture #(
    parameter int DW    = 9,
    parameter int AW    = 12,
    parameter int DEPTH = 1280
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic          rd_en,
    input  logic          rd_mode,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] rd_offset,
    output logic [DW-1:0] re_out1,
    output logic [DW-1:0] re_out2,
    output logic [DW-1:0] im_out1,
    output logic [DW-1:0] im_out2,
    output logic          rd_valid,
    output logic          busy,
    output logic          full,
    output logic          frame_done,
    output logic [AW-1:0] wr_count
);
    localparam int          IW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_X = DEPTH[AW:0];
    localparam logic [AW:0] LAST_X  = DEPTH_X - 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]    state;
    logic          accept;
    logic          rd_ok;
    logic          addr_ok;
    logic          off_ok;
    logic [IW-1:0] lag;

    logic [DW-1:0] mem_re [DEPTH];
    logic [DW-1:0] mem_im [DEPTH];

    logic [DW-1:0] re1_p1, re2_p1, im1_p1, im2_p1;
    logic          vld_p1;

    // The sum is one bit wider than the operands, so the wrap never loses a carry.
    function automatic logic [IW-1:0] lag_addr(input logic [AW-1:0] a, input logic [AW-1:0] o);
        logic [AW:0] sum;
        logic [AW:0] wrapped;
        sum     = {1'b0, a} + {1'b0, o};
        wrapped = sum % DEPTH_X;
        return wrapped[IW-1:0];
    endfunction

    assign in_ready = (state == S_FILL);
    assign busy     = (state == S_FILL);
    assign full     = (state == S_FULL);
    assign accept   = in_ready && in_valid && !start;
    assign rd_ok    = full && rd_en && !start;
    assign addr_ok  = ({1'b0, rd_addr} < DEPTH_X);
    assign off_ok   = ({1'b0, rd_offset} < DEPTH_X);
    assign lag      = lag_addr(rd_addr, rd_offset);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_count   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                state    <= S_FILL;
                wr_count <= '0;
            end else if (accept) begin
                wr_count <= wr_count + 1'b1;
                if ({1'b0, wr_count} == LAST_X) begin
                    state      <= S_FULL;
                    frame_done <= 1'b1;
                end
            end
        end
    end

    // Capture arrays keep their contents across frames and through reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[wr_count[IW-1:0]] <= in_re;
            mem_im[wr_count[IW-1:0]] <= in_im;
        end
    end

    // p1: registered read port; the lagged pair only moves in dual mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            re1_p1 <= '0;
            im1_p1 <= '0;
            re2_p1 <= '0;
            im2_p1 <= '0;
        end else begin
            vld_p1 <= rd_ok;
            if (rd_ok) begin
                re1_p1 <= addr_ok ? mem_re[rd_addr[IW-1:0]] : '0;
                im1_p1 <= addr_ok ? mem_im[rd_addr[IW-1:0]] : '0;
                if (rd_mode) begin
                    re2_p1 <= off_ok ? mem_re[lag] : '0;
                    im2_p1 <= off_ok ? mem_im[lag] : '0;
                end
            end
        end
    end

    assign re_out1  = re1_p1;
    assign im_out1  = im1_p1;
    assign re_out2  = re2_p1;
    assign im_out2  = im2_p1;
    assign rd_valid = vld_p1;

endmodule
